add_num_csr_ctrl: RTL and testbench

- MMIO CSR front end for the add-two-numbers AFU. It sits directly upstream of the adder/write datapath and is driven from the decoded CCI-P c0 MMIO request fields.
- Captures the result-buffer address and both operands, then issues a single-cycle start to the datapath.
- Tracks busy/done/timeout and returns every MMIO read, including the DFH/UUID feature-list words, with one-cycle latency.

---
 rtl/add_num_csr_pkg.sv | 56 +++++
 rtl/add_num_csr_ctrl_if.sv | 35 +++
 rtl/add_num_timeout_cnt.sv | 23 ++
 rtl/add_num_csr_ctrl.sv | 165 ++++++++++++++++
 tb/tb_add_num_csr_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_num_csr_pkg.sv
// Shared definitions for the add-two-numbers AFU CSR front end:
// word-address map, STATUS/CTRL bit positions, FSM state and status view.
package add_num_csr_pkg;

  localparam logic [15:0] CSR_DFH      = 16'h0000;
  localparam logic [15:0] CSR_ID_L     = 16'h0002;
  localparam logic [15:0] CSR_ID_H     = 16'h0004;
  localparam logic [15:0] CSR_RSVD0    = 16'h0006;
  localparam logic [15:0] CSR_RSVD1    = 16'h0008;
  localparam logic [15:0] CSR_BUF_ADDR = 16'h000A;
  localparam logic [15:0] CSR_OPERANDS = 16'h000C;
  localparam logic [15:0] CSR_CTRL     = 16'h000E;
  localparam logic [15:0] CSR_STATUS   = 16'h0010;
  localparam logic [15:0] CSR_RESULT   = 16'h0012;

  localparam int ST_BUSY_BIT       = 0;
  localparam int ST_DONE_BIT       = 1;
  localparam int ST_TIMEOUT_BIT    = 2;
  localparam int ST_ERR_BIT        = 3;
  localparam int ST_ADDR_VALID_BIT = 4;
  localparam int ST_RUN_CNT_LSB    = 16;

  localparam int CTRL_GO_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Feature header: type AFU (4'h1) and end-of-list set.
  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } t_ctrl_state;

  typedef struct packed {
    logic [15:0] run_cnt;
    logic        addr_valid;
    logic        err;
    logic        timeout;
    logic        done;
    logic        busy;
  } t_status;

  function automatic logic [63:0] status_word(input t_status s);
    logic [63:0] w;
    w                          = '0;
    w[ST_BUSY_BIT]             = s.busy;
    w[ST_DONE_BIT]             = s.done;
    w[ST_TIMEOUT_BIT]          = s.timeout;
    w[ST_ERR_BIT]              = s.err;
    w[ST_ADDR_VALID_BIT]       = s.addr_valid;
    w[ST_RUN_CNT_LSB +: 16]    = s.run_cnt;
    return w;
  endfunction

endpackage

// File: rtl/add_num_csr_ctrl_if.sv
// MMIO request/response and datapath launch/completion signals of the CSR block.
// Handshake: a request is taken on any edge where *_valid is high (no ready); rd_rsp_valid follows one cycle later.
interface add_num_csr_ctrl_if;
  import add_num_csr_pkg::*;

  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;
  logic        start;
  logic [41:0] buf_addr;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        dp_done;
  logic [8:0]  dp_result;
  t_ctrl_state dbg_state;

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    input  dp_done, dp_result,
    output rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
    output start, buf_addr, operand_a, operand_b, dbg_state
  );

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    output dp_done, dp_result,
    input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
    input  start, buf_addr, operand_a, operand_b, dbg_state
  );
endinterface

// File: rtl/add_num_timeout_cnt.sv
// Busy-cycle counter for the add-num CSR controller; o_expired is high
// while the count equals TIMEOUT_CYCLES - 1.
module add_num_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + 16'd1;
  end

  assign o_expired = (r_cnt == LAST_CNT);
endmodule

// File: rtl/add_num_csr_ctrl.sv
// MMIO CSR front end of the add-two-numbers AFU: captures buffer address and
// operands, launches the datapath, tracks busy/done/timeout, answers reads in one cycle.
module add_num_csr_ctrl
  import add_num_csr_pkg::*;
#(
  parameter logic [127:0] AFU_ID         = 128'h0,
  parameter int           TIMEOUT_CYCLES = 4096,
  parameter int           RUN_CNT_W      = 16
) (
  input logic               clk,
  input logic               reset_n,
  add_num_csr_ctrl_if.slave bus
);

  t_ctrl_state          r_state, w_state_nxt;
  logic [41:0]          r_buf_addr;
  logic [7:0]           r_op_a, r_op_b;
  logic [8:0]           r_result;
  logic                 r_done, r_timeout, r_err, r_addr_valid;
  logic [RUN_CNT_W-1:0] r_run_cnt;
  logic                 r_rd_valid;
  logic [8:0]           r_rd_tid;
  logic [63:0]          r_rd_data;

  logic        w_idle, w_wr_buf, w_wr_ops, w_wr_ctrl, w_go, w_clr;
  logic        w_launch, w_complete, w_timeout_evt, w_go_err, w_wr_err;
  logic        w_expired;
  logic [63:0] w_rd_data;
  t_status     w_status;
  logic        w_unused_wr_data;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_buf  = bus.mmio_wr_valid && (bus.mmio_addr == CSR_BUF_ADDR);
  assign w_wr_ops  = bus.mmio_wr_valid && (bus.mmio_addr == CSR_OPERANDS);
  assign w_wr_ctrl = bus.mmio_wr_valid && (bus.mmio_addr == CSR_CTRL);
  assign w_go      = w_wr_ctrl && bus.mmio_wr_data[CTRL_GO_BIT];
  assign w_clr     = w_wr_ctrl && bus.mmio_wr_data[CTRL_CLR_BIT];
  assign w_wr_err  = (w_wr_buf || w_wr_ops) && !w_idle;
  assign w_unused_wr_data = ^bus.mmio_wr_data[63:42];

  add_num_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (r_state == S_LAUNCH),
    .i_en      (r_state == S_BUSY),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_complete    = 1'b0;
    w_timeout_evt = 1'b0;
    w_go_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (r_addr_valid) begin
            w_state_nxt = S_LAUNCH;
            w_launch    = 1'b1;
          end else begin
            w_go_err = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_BUSY;
        w_go_err    = w_go;
      end
      S_BUSY: begin
        w_go_err = w_go;
        // A completion on the expiry cycle takes precedence over the timeout.
        if (bus.dp_done) begin
          w_state_nxt = S_IDLE;
          w_complete  = 1'b1;
        end else if (w_expired) begin
          w_state_nxt   = S_IDLE;
          w_timeout_evt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_buf_addr   <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_addr_valid <= 1'b0;
      r_run_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_buf && w_idle) begin
        r_buf_addr   <= bus.mmio_wr_data[41:0];
        r_addr_valid <= 1'b1;
      end
      if (w_wr_ops && w_idle) begin
        r_op_a <= bus.mmio_wr_data[7:0];
        r_op_b <= bus.mmio_wr_data[15:8];
      end
      if (w_complete) begin
        r_result  <= bus.dp_result;
        r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);
      end
      // Clear acts before the same write's go, so a fresh error survives it.
      r_done    <= w_complete | (r_done & ~w_launch & ~w_clr);
      r_timeout <= w_timeout_evt | (r_timeout & ~w_launch & ~w_clr);
      r_err     <= w_go_err | w_wr_err | (r_err & ~w_clr);
    end
  end

  always_comb begin
    w_status.run_cnt    = 16'(r_run_cnt);
    w_status.addr_valid = r_addr_valid;
    w_status.err        = r_err;
    w_status.timeout    = r_timeout;
    w_status.done       = r_done;
    w_status.busy       = !w_idle;
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.mmio_addr)
      CSR_DFH:      w_rd_data = DFH_VALUE;
      CSR_ID_L:     w_rd_data = AFU_ID[63:0];
      CSR_ID_H:     w_rd_data = AFU_ID[127:64];
      CSR_BUF_ADDR: w_rd_data = {22'b0, r_buf_addr};
      CSR_OPERANDS: w_rd_data = {48'b0, r_op_b, r_op_a};
      CSR_STATUS:   w_rd_data = status_word(w_status);
      CSR_RESULT:   w_rd_data = {55'b0, r_result};
      CSR_RSVD0, CSR_RSVD1, CSR_CTRL: w_rd_data = '0;
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_tid   <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.mmio_rd_valid;
      if (bus.mmio_rd_valid) begin
        r_rd_tid  <= bus.mmio_tid;
        r_rd_data <= w_rd_data;
      end
    end
  end

  assign bus.rd_rsp_valid = r_rd_valid;
  assign bus.rd_rsp_tid   = r_rd_tid;
  assign bus.rd_rsp_data  = r_rd_data;
  assign bus.start        = (r_state == S_LAUNCH);
  assign bus.buf_addr     = r_buf_addr;
  assign bus.operand_a    = r_op_a;
  assign bus.operand_b    = r_op_b;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_add_num_csr_ctrl.sv
// Self-checking bench for add_num_csr_ctrl: directed scenarios plus randomized
// runs checked against a register-map level model.
module tb_add_num_csr_ctrl;
  import add_num_csr_pkg::*;

  localparam logic [127:0] TB_AFU_ID  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam int           TB_TIMEOUT = 8;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  add_num_csr_ctrl_if bus();

  add_num_csr_ctrl #(
    .AFU_ID(TB_AFU_ID), .TIMEOUT_CYCLES(TB_TIMEOUT), .RUN_CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model of the visible CSR contents
  logic [41:0] m_buf;
  logic [7:0]  m_a, m_b;
  logic [8:0]  m_result;
  logic        m_done, m_timeout, m_err, m_addr_valid;
  logic [15:0] m_run_cnt;
  logic [15:0] rd_addr_q[$];
  logic [63:0] exp_q[$];

  function automatic logic [63:0] exp_status(input logic busy);
    return {32'b0, m_run_cnt, 11'b0, m_addr_valid, m_err, m_timeout, m_done, busy};
  endfunction

  task automatic model_reset();
    m_buf = '0; m_a = '0; m_b = '0; m_result = '0;
    m_done = 0; m_timeout = 0; m_err = 0; m_addr_valid = 0; m_run_cnt = '0;
  endtask

  // start-pulse monitor
  int          start_cnt;
  logic [41:0] seen_buf;
  logic [7:0]  seen_a, seen_b;
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      start_cnt++;
      seen_buf = bus.buf_addr;
      seen_a   = bus.operand_a;
      seen_b   = bus.operand_b;
    end
  end

  // driver tasks (all entered and left at a negedge)
  task automatic mmio_write(input logic [15:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.mmio_wr_valid = 1'b1;
    bus.mmio_addr     = addr;
    bus.mmio_wr_data  = data;
    @(negedge clk);
    bus.mmio_wr_valid = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] addr, input logic [8:0] tid, output logic early,
                           output logic vld, output logic [8:0] rtid, output logic [63:0] data);
    @(negedge clk);
    bus.mmio_rd_valid = 1'b1;
    bus.mmio_addr     = addr;
    bus.mmio_tid      = tid;
    #1 early = bus.rd_rsp_valid;
    @(negedge clk);
    bus.mmio_rd_valid = 1'b0;
    vld  = bus.rd_rsp_valid;
    rtid = bus.rd_rsp_tid;
    data = bus.rd_rsp_data;
  endtask

  task automatic wait_state(input t_ctrl_state st, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.dbg_state == st) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic dp_pulse(input logic [8:0] res);
    bus.dp_done   = 1'b1;
    bus.dp_result = res;
    @(negedge clk);
    bus.dp_done   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.mmio_wr_valid = 0; bus.mmio_rd_valid = 0; bus.mmio_addr = '0;
    bus.mmio_tid = '0; bus.mmio_wr_data = '0; bus.dp_done = 0; bus.dp_result = '0;
    start_cnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dbg_state !== S_IDLE || bus.start !== 1'b0 || bus.rd_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl state=%0d start=%b rsp=%b required 0/0/0", bus.dbg_state, bus.start, bus.rd_rsp_valid);
    end
    checks++;
    if ({bus.buf_addr, bus.operand_a, bus.operand_b} !== 58'd0) begin
      errors++;
      $display("FAIL reset_regs buf=%h a=%h b=%h required 0", bus.buf_addr, bus.operand_a, bus.operand_b);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_id_read();
    logic [15:0] addrs [8];
    logic [63:0] exps  [8];
    logic early, vld;
    logic [8:0] rtid;
    logic [63:0] d;
    addrs = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h0E, 16'h13, 16'h40};
    exps  = '{64'h1000_0100_0000_0000, TB_AFU_ID[63:0], TB_AFU_ID[127:64], 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    for (int i = 0; i < 8; i++) begin
      mmio_read(addrs[i], 9'h005, early, vld, rtid, d);
      checks++;
      if (early !== 1'b0 || vld !== 1'b1 || rtid !== 9'h005) begin
        errors++;
        $display("FAIL rd_timing addr=%h early=%b valid=%b tid=%h required 0/1/005", addrs[i], early, vld, rtid);
      end
      checks++;
      if (d !== exps[i]) begin
        errors++;
        $display("FAIL rd_data addr=%h got %h required %h", addrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic check_reg(input string name, input logic [15:0] addr, input logic [63:0] exp);
    logic early, vld;
    logic [8:0] rtid, tid;
    logic [63:0] d;
    tid = 9'($urandom_range(0, 511));
    mmio_read(addr, tid, early, vld, rtid, d);
    checks++;
    if (vld !== 1'b1 || rtid !== tid || d !== exp) begin
      errors++;
      $display("FAIL %s valid=%b tid=%h data=%h required 1 %h %h", name, vld, rtid, d, tid, exp);
    end
  endtask

  task automatic test_go_no_addr();
    start_cnt = 0;
    mmio_write(CSR_CTRL, 64'h1);
    m_err = 1;
    @(negedge clk);
    checks++;
    if (start_cnt !== 0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL go_no_addr starts=%0d state=%0d required 0 idle", start_cnt, bus.dbg_state);
    end
    check_reg("go_no_addr_status", CSR_STATUS, exp_status(1'b0));
    mmio_write(CSR_CTRL, 64'h2);
    m_err = 0;
    check_reg("clear_err_status", CSR_STATUS, exp_status(1'b0));
  endtask

  task automatic test_basic_run();
    logic ok;
    mmio_write(CSR_BUF_ADDR, 64'h1234);
    m_buf = 42'h1234; m_addr_valid = 1;
    mmio_write(CSR_OPERANDS, 64'h0503);
    m_a = 8'd3; m_b = 8'd5;
    start_cnt = 0;
    mmio_write(CSR_CTRL, 64'h1);
    wait_state(S_BUSY, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_busy never reached"); end
    dp_pulse(9'(m_a) + 9'(m_b));
    m_result = 9'(m_a) + 9'(m_b); m_done = 1; m_run_cnt = m_run_cnt + 16'd1;
    @(negedge clk);
    checks++;
    if (start_cnt !== 1 || seen_buf !== 42'h1234 || seen_a !== 8'd3 || seen_b !== 8'd5) begin
      errors++;
      $display("FAIL basic_start starts=%0d buf=%h a=%h b=%h required 1 1234 03 05", start_cnt, seen_buf, seen_a, seen_b);
    end
    check_reg("basic_status", CSR_STATUS, 64'h0000_0000_0001_0012);
    check_reg("basic_result", CSR_RESULT, 64'd8);
  endtask

  task automatic test_busy_writes();
    logic ok;
    start_cnt = 0;
    mmio_write(CSR_CTRL, 64'h1);
    m_done = 0; m_timeout = 0;
    wait_state(S_BUSY, ok);
    mmio_write(CSR_OPERANDS, 64'hFFFF);
    mmio_write(CSR_CTRL, 64'h1);
    m_err = 1;
    checks++;
    if (!ok || bus.dbg_state !== S_BUSY || bus.operand_a !== 8'd3 || bus.operand_b !== 8'd5) begin
      errors++;
      $display("FAIL busy_hold ok=%b state=%0d a=%h b=%h required busy 03 05", ok, bus.dbg_state, bus.operand_a, bus.operand_b);
    end
    dp_pulse(9'd8);
    m_result = 9'd8; m_done = 1; m_run_cnt = m_run_cnt + 16'd1;
    @(negedge clk);
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL busy_starts got %0d required 1", start_cnt); end
    check_reg("busy_status", CSR_STATUS, exp_status(1'b0));
    check_reg("busy_operands", CSR_OPERANDS, {48'b0, m_b, m_a});
  endtask

  task automatic test_timeout();
    logic ok;
    int busy_cycles;
    mmio_write(CSR_CTRL, 64'h2);
    m_done = 0; m_timeout = 0; m_err = 0;
    mmio_write(CSR_CTRL, 64'h1);
    wait_state(S_BUSY, ok);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.dbg_state != S_BUSY) break;
      busy_cycles++;
      @(negedge clk);
    end
    m_timeout = 1;
    checks++;
    if (!ok || busy_cycles != TB_TIMEOUT || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL timeout_len busy_cycles=%0d required %0d", busy_cycles, TB_TIMEOUT);
    end
    check_reg("timeout_status", CSR_STATUS, exp_status(1'b0));
    check_reg("timeout_result", CSR_RESULT, {55'b0, m_result});
  endtask

  task automatic test_timeout_race();
    logic ok;
    logic [8:0] r;
    mmio_write(CSR_CTRL, 64'h1);
    m_timeout = 0; m_done = 0;
    wait_state(S_BUSY, ok);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    checks++;
    if (!ok || bus.dbg_state !== S_BUSY) begin
      errors++;
      $display("FAIL race_setup state=%0d required busy on last cycle", bus.dbg_state);
    end
    r = 9'($urandom_range(0, 511));
    dp_pulse(r);
    m_result = r; m_done = 1; m_run_cnt = m_run_cnt + 16'd1;
    check_reg("race_status", CSR_STATUS, exp_status(1'b0));
    check_reg("race_result", CSR_RESULT, {55'b0, m_result});
  endtask

  task automatic test_clear_races();
    logic ok;
    logic [8:0] r;
    start_cnt = 0;
    mmio_write(CSR_CTRL, 64'h1);
    m_done = 0;
    wait_state(S_BUSY, ok);
    mmio_write(CSR_CTRL, 64'h1);
    r = 9'($urandom_range(0, 511));
    bus.mmio_wr_valid = 1; bus.mmio_addr = CSR_CTRL; bus.mmio_wr_data = 64'h2;
    dp_pulse(r);
    bus.mmio_wr_valid = 0;
    m_err = 0; m_timeout = 0; m_done = 1; m_result = r; m_run_cnt = m_run_cnt + 16'd1;
    check_reg("clear_with_done", CSR_STATUS, exp_status(1'b0));
    mmio_write(CSR_CTRL, 64'h1);
    m_done = 0;
    wait_state(S_BUSY, ok);
    mmio_write(CSR_CTRL, 64'h1);
    dp_pulse(r);
    m_err = 1; m_done = 1; m_run_cnt = m_run_cnt + 16'd1;
    check_reg("err_before_clear_go", CSR_STATUS, exp_status(1'b0));
    mmio_write(CSR_CTRL, 64'h3);
    m_err = 0; m_done = 0; m_timeout = 0;
    wait_state(S_BUSY, ok);
    dp_pulse(r);
    m_done = 1; m_run_cnt = m_run_cnt + 16'd1;
    @(negedge clk);
    checks++;
    if (!ok || start_cnt !== 3) begin errors++; $display("FAIL clear_go_starts got %0d required 3", start_cnt); end
    check_reg("clear_go_status", CSR_STATUS, exp_status(1'b0));
  endtask

  task automatic test_random_runs();
    logic ok, early, vld;
    logic [63:0] d, bdat, odat;
    logic [8:0] rtid;
    logic [15:0] a;
    int delay;
    for (int it = 0; it < 12; it++) begin
      bdat = {$urandom, $urandom};
      odat = {$urandom, $urandom};
      mmio_write(CSR_BUF_ADDR, bdat);
      m_buf = bdat[41:0]; m_addr_valid = 1;
      mmio_write(CSR_OPERANDS, odat);
      m_a = odat[7:0]; m_b = odat[15:8];
      if ($urandom_range(0, 2) == 0) begin
        mmio_write(CSR_CTRL, 64'h2);
        m_done = 0; m_timeout = 0; m_err = 0;
      end
      start_cnt = 0;
      mmio_write(CSR_CTRL, 64'h1);
      m_done = 0; m_timeout = 0;
      wait_state(S_BUSY, ok);
      delay = int'($urandom_range(0, 10));
      repeat (delay) @(negedge clk);
      dp_pulse(9'(m_a) + 9'(m_b));
      // the response lands on busy cycle delay+1; later ones arrive after the timeout
      if (delay + 1 <= TB_TIMEOUT) begin
        m_done = 1; m_result = 9'(m_a) + 9'(m_b); m_run_cnt = m_run_cnt + 16'd1;
      end else begin
        m_timeout = 1;
      end
      @(negedge clk);
      checks++;
      if (!ok || start_cnt !== 1 || seen_buf !== m_buf || seen_a !== m_a || seen_b !== m_b) begin
        errors++;
        $display("FAIL rand_start it=%0d starts=%0d buf=%h a=%h b=%h required 1 %h %h %h",
                 it, start_cnt, seen_buf, seen_a, seen_b, m_buf, m_a, m_b);
      end
      rd_addr_q.push_back(CSR_STATUS);   exp_q.push_back(exp_status(1'b0));
      rd_addr_q.push_back(CSR_RESULT);   exp_q.push_back({55'b0, m_result});
      rd_addr_q.push_back(CSR_BUF_ADDR); exp_q.push_back({22'b0, m_buf});
      rd_addr_q.push_back(CSR_OPERANDS); exp_q.push_back({48'b0, m_b, m_a});
      while (exp_q.size() > 0) begin
        a = rd_addr_q.pop_front();
        mmio_read(a, 9'(it), early, vld, rtid, d);
        checks++;
        if (vld !== 1'b1 || d !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_read it=%0d addr=%h valid=%b got %h required %h", it, a, vld, d, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_async_reset();
    logic ok;
    mmio_write(CSR_CTRL, 64'h1);
    wait_state(S_BUSY, ok);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || bus.dbg_state !== S_IDLE || bus.start !== 1'b0 || bus.buf_addr !== 42'd0 || bus.operand_a !== 8'd0) begin
      errors++;
      $display("FAIL async_reset state=%0d buf=%h a=%h required idle 0 0", bus.dbg_state, bus.buf_addr, bus.operand_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    dp_pulse(9'h1FF);
    check_reg("post_reset_status", CSR_STATUS, exp_status(1'b0));
    check_reg("post_reset_result", CSR_RESULT, 64'd0);
    check_reg("post_reset_buf", CSR_BUF_ADDR, 64'd0);
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_go_no_addr();
    test_basic_run();
    test_busy_writes();
    test_timeout();
    test_timeout_race();
    test_clear_races();
    test_random_runs();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
